// File: rtl/sp6_switch_debounce.sv
// sp6_switch_debounce: synchronises and debounces the board DIP switches in the
// ext_clk_25m domain. Each bit gets a 2-FF synchroniser and a counter. A new level
// must persist for DEBOUNCE_CYCLES consecutive samples before it is accepted.
// Ports:
//   ext_clk_25m  - system clock, 25 MHz
//   ext_rst_n    - synchronous active-low reset
//   switch       - raw asynchronous switch pins (may bounce)
//   sw_stable    - debounced switch level
//   sw_rise      - one-cycle pulse per bit on a debounced 0->1 transition
//   sw_fall      - one-cycle pulse per bit on a debounced 1->0 transition
//   sw_changed   - one-cycle pulse whenever any bit rises or falls
//   sw_valid     - high once the startup debounce window has elapsed after reset
module sp6_switch_debounce #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic             ext_clk_25m,
    input  logic             ext_rst_n,
    input  logic [WIDTH-1:0] switch,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_changed,
    output logic             sw_valid
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 3);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(DEBOUNCE_CYCLES + 2);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [CNT_W-1:0] cnt     [WIDTH];
    logic [CNT_W-1:0] cnt_nxt [WIDTH];
    logic [WIDTH-1:0] upd_c;
    logic [CNT_W-1:0] start_cnt;

    // Per-bit debounce counter next state. The counter clears whenever the
    // synchronised level matches the accepted level, or when a new level is
    // accepted, so it can never wrap.
    always_comb begin
        upd_c = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_nxt[i] = '0;
            if (sync2[i] != sw_stable[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    upd_c[i] = 1'b1;
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Synchroniser, counters, debounced level and edge pulses.
    always_ff @(posedge ext_clk_25m) begin
        if (!ext_rst_n) begin
            sync1      <= '0;
            sync2      <= '0;
            sw_stable  <= '0;
            sw_rise    <= '0;
            sw_fall    <= '0;
            sw_changed <= 1'b0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1     <= switch;
            sync2     <= sync1;
            sw_stable <= sw_stable ^ upd_c;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt[i] <= cnt_nxt[i];
            end
            // Edges that land during startup only settle the level; no pulses.
            if (sw_valid) begin
                sw_rise    <= upd_c & sync2;
                sw_fall    <= upd_c & ~sync2;
                sw_changed <= |upd_c;
            end else begin
                sw_rise    <= '0;
                sw_fall    <= '0;
                sw_changed <= 1'b0;
            end
        end
    end

    // Startup window: start_cnt holds the number of edges seen since release.
    // sw_valid rises on edge DEBOUNCE_CYCLES+3.
    always_ff @(posedge ext_clk_25m) begin
        if (!ext_rst_n) begin
            start_cnt <= '0;
            sw_valid  <= 1'b0;
        end else if (!sw_valid) begin
            if (start_cnt == START_LAST) begin
                sw_valid <= 1'b1;
            end else begin
                start_cnt <= start_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sp6_switch_debounce.sv
// Directed testbench for sp6_switch_debounce with DEBOUNCE_CYCLES=8.
module tb_sp6_switch_debounce;

    localparam int unsigned W = 4;
    localparam int unsigned D = 8;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] sw;
    logic [W-1:0] sw_stable;
    logic [W-1:0] sw_rise;
    logic [W-1:0] sw_fall;
    logic         sw_changed;
    logic         sw_valid;

    int total;
    int bad;

    sp6_switch_debounce #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .ext_clk_25m (clk),
        .ext_rst_n   (rst_n),
        .switch      (sw),
        .sw_stable   (sw_stable),
        .sw_rise     (sw_rise),
        .sw_fall     (sw_fall),
        .sw_changed  (sw_changed),
        .sw_valid    (sw_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".rise"}, 32'(sw_rise), 32'h0);
        chk({tag, ".fall"}, 32'(sw_fall), 32'h0);
        chk({tag, ".chg"},  32'(sw_changed), 32'h0);
    endtask

    // Reset has just been released with the pins at 'pins'; walk the startup window.
    task automatic startup(input string tag, input logic [W-1:0] pins);
        for (int k = 1; k <= 12; k++) begin
            step();
            chk_quiet(tag);
            chk({tag, ".stable"}, 32'(sw_stable), (k >= 10) ? 32'(pins) : 32'h0);
            chk({tag, ".valid"},  32'(sw_valid),  (k >= 11) ? 32'h1 : 32'h0);
        end
    endtask

    // Drive new pin levels; the next edge is e0. The accepted level changes at e0+9.
    task automatic expect_change(input string tag, input logic [W-1:0] old_v,
                                 input logic [W-1:0] new_v);
        sw = new_v;
        for (int k = 0; k <= 8; k++) begin
            step();
            chk_quiet(tag);
            chk({tag, ".hold"}, 32'(sw_stable), 32'(old_v));
        end
        step();
        chk({tag, ".stable"}, 32'(sw_stable), 32'(new_v));
        chk({tag, ".rise"},   32'(sw_rise), 32'(new_v & ~old_v));
        chk({tag, ".fall"},   32'(sw_fall), 32'(old_v & ~new_v));
        chk({tag, ".chg"},    32'(sw_changed), 32'h1);
        step();
        chk_quiet({tag, ".after"});
        chk({tag, ".kept"}, 32'(sw_stable), 32'(new_v));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        sw    = 4'hF;

        // 1: reset with all switches on, then the startup window.
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rst.stable", 32'(sw_stable), 32'h0);
            chk("rst.valid",  32'(sw_valid), 32'h0);
            chk_quiet("rst");
        end
        rst_n = 1'b1;
        startup("start", 4'hF);

        // All bits released together: one fall pulse covering every bit.
        expect_change("allfall", 4'hF, 4'h0);

        // 2: clean press on bit0.
        expect_change("press0", 4'h0, 4'h1);

        // 3: bit1 bounces with 3-sample runs, then settles high.
        for (int s = 0; s < 10; s++) begin
            sw[1] = ~sw[1];
            for (int k = 0; k < 3; k++) begin
                step();
                chk_quiet("bounce");
                chk("bounce.stable", 32'(sw_stable), 32'h1);
            end
        end
        expect_change("settle1", 4'h1, 4'h3);

        // 4a: 7-sample glitch on bit2 must be ignored.
        sw[2] = 1'b1;
        for (int k = 0; k < 7; k++) step();
        sw[2] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            chk_quiet("glitch7");
            chk("glitch7.stable", 32'(sw_stable), 32'h3);
        end

        // 4b: 8-sample glitch is accepted, then the return to 0 is accepted too.
        sw[2] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk_quiet("glitch8.pre");
        end
        sw[2] = 1'b0;
        step();
        chk_quiet("glitch8.e8");
        step();
        chk("glitch8.rise",   32'(sw_rise), 32'h4);
        chk("glitch8.chg",    32'(sw_changed), 32'h1);
        chk("glitch8.stable", 32'(sw_stable), 32'h7);
        for (int k = 0; k < 7; k++) begin
            step();
            chk_quiet("glitch8.mid");
            chk("glitch8.mid.stable", 32'(sw_stable), 32'h7);
        end
        step();
        chk("glitch8.fall",    32'(sw_fall), 32'h4);
        chk("glitch8.frise",   32'(sw_rise), 32'h0);
        chk("glitch8.fchg",    32'(sw_changed), 32'h1);
        chk("glitch8.fstable", 32'(sw_stable), 32'h3);
        step();
        chk_quiet("glitch8.end");

        // 5: bit0 falls and bit3 rises in the same sample.
        expect_change("simul", 4'h3, 4'hA);

        // 6: reset five cycles into a bit0 change, then the startup repeats.
        sw = 4'hB;
        for (int k = 0; k < 5; k++) step();
        rst_n = 1'b0;
        step();
        chk("midrst.stable", 32'(sw_stable), 32'h0);
        chk("midrst.valid",  32'(sw_valid), 32'h0);
        chk_quiet("midrst");
        rst_n = 1'b1;
        startup("restart", 4'hB);
        for (int k = 0; k < 12; k++) begin
            step();
            chk_quiet("restart.tail");
            chk("restart.tail.stable", 32'(sw_stable), 32'hB);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
